// File: rtl/div_sequencer.sv
// Multi-cycle divider for div/divu: restoring shift-subtract, one quotient bit
// per cycle, with sign correction, divide-by-zero shortcut and flush support.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [2*WIDTH:0] work;
    logic [WIDTH-1:0] divisor;
    logic             sign_q;
    logic             sign_r;

    logic [2*WIDTH:0] shifted;
    logic [WIDTH+1:0] diff;
    logic [2*WIDTH:0] work_next;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] op1_abs;
    logic [WIDTH-1:0] op2_abs;

    // One restoring step: shift left, trial-subtract the divisor from the
    // upper half, keep the difference and set the quotient bit if no borrow.
    always_comb begin
        shifted   = work << 1;
        diff      = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b0, divisor};
        work_next = diff[WIDTH+1] ? shifted
                                  : ({diff[WIDTH:0], shifted[WIDTH-1:0]} | (2*WIDTH+1)'(1));
        quo       = work_next[WIDTH-1:0];
        rem       = work_next[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        op1_abs = (signed_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
        op2_abs = (signed_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
    end

    assign ready_o = (state == END);
    assign stall_o = start_i && !annul_i && (state != END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            work     <= '0;
            divisor  <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && !annul_i) begin
                        count   <= '0;
                        work    <= {{(WIDTH+1){1'b0}}, op1_abs};
                        divisor <= op2_abs;
                        sign_q  <= signed_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        sign_r  <= signed_i && opdata1_i[WIDTH-1];
                        state   <= (opdata2_i == '0) ? BYZERO : ON;
                    end
                end
                BYZERO: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else begin
                        result_o <= '0;
                        state    <= END;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state <= IDLE;
                        count <= '0;
                    end else begin
                        work  <= work_next;
                        count <= count + 1'b1;
                        // The last step's outcome goes straight into the result
                        // so the answer is visible on the first END cycle.
                        if (count == CW'(WIDTH - 1)) begin
                            result_o <= {sign_r ? (~rem + 1'b1) : rem,
                                         sign_q ? (~quo + 1'b1) : quo};
                            state    <= END;
                        end
                    end
                end
                END: begin
                    if (annul_i || !start_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
